// File: rtl/gcd_op_loader_pkg.sv
// Shared types for the GCD operand loader: operand pair payload and input phase.
package gcd_pkg;

  localparam int unsigned WL_DEFAULT = 8;

  typedef struct packed {
    logic [WL_DEFAULT-1:0] a;
    logic [WL_DEFAULT-1:0] b;
  } op_pair_t;

  typedef enum logic {
    WAIT_A,
    WAIT_B
  } phase_e;

endpackage

// File: rtl/gcd_op_loader_if.sv
// Byte input and operand-pair output handshakes of the GCD operand loader.
interface gcd_op_loader_if
  import gcd_pkg::*;
#(
  parameter int unsigned WL    = WL_DEFAULT,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WL-1:0] in_data;
  logic          in_val;
  logic          in_rdy;
  logic [WL-1:0] op_a;
  logic [WL-1:0] op_b;
  logic          ops_val;
  logic          ops_rdy;
  logic [CW-1:0] count;

  modport master (
    output in_data, in_val, ops_rdy,
    input  in_rdy, op_a, op_b, ops_val, count
  );

  modport slave (
    input  in_data, in_val, ops_rdy,
    output in_rdy, op_a, op_b, ops_val, count
  );

endinterface

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO of operand pairs; storage is reset so the head is never X.
module gcd_pair_fifo
  import gcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  op_pair_t                 pair_i,
  input  logic                     pop_i,
  output op_pair_t                 head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  op_pair_t      mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= pair_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gcd_op_loader.sv
// Pairs consecutive input bytes as (A, B) and buffers them for the GCD core.
// Optional GCD_OP_LOADER_SWAP_EN: store each pair ordered so that op_a >= op_b.
module gcd_op_loader
  import gcd_pkg::*;
#(
  parameter int unsigned WL    = WL_DEFAULT,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  gcd_op_loader_if.slave  bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  phase_e        phase_q, phase_d;
  logic [WL-1:0] a_hold_q, a_hold_d;
  logic          push, full, empty, in_rdy, in_xfer;
  op_pair_t      pair, head;
  logic [CW-1:0] count;

  // B only waits for a free slot; no path from ops_rdy so a full FIFO stalls B a cycle.
  assign in_rdy  = (phase_q == WAIT_A) || !full;
  assign in_xfer = bus.in_val && in_rdy;

  always_comb begin
    phase_d  = phase_q;
    a_hold_d = a_hold_q;
    push     = 1'b0;
    pair.a   = WL_DEFAULT'(a_hold_q);
    pair.b   = WL_DEFAULT'(bus.in_data);
`ifdef GCD_OP_LOADER_SWAP_EN
    if (bus.in_data > a_hold_q) begin
      pair.a = WL_DEFAULT'(bus.in_data);
      pair.b = WL_DEFAULT'(a_hold_q);
    end
`endif
    case (phase_q)
      WAIT_A: begin
        if (in_xfer) begin
          a_hold_d = bus.in_data;
          phase_d  = WAIT_B;
        end
      end
      WAIT_B: begin
        if (in_xfer) begin
          push    = 1'b1;
          phase_d = WAIT_A;
        end
      end
      default: phase_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= WAIT_A;
      a_hold_q <= '0;
    end else begin
      phase_q  <= phase_d;
      a_hold_q <= a_hold_d;
    end
  end

  gcd_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pair_i  (pair),
    .pop_i   (bus.ops_rdy),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign bus.in_rdy  = in_rdy;
  assign bus.ops_val = !empty;
  assign bus.op_a    = WL'(head.a);
  assign bus.op_b    = WL'(head.b);
  assign bus.count   = count;

endmodule

// File: tb/tb_gcd_op_loader.sv
// Directed self-checking bench for gcd_op_loader (default and swap builds).
module tb_gcd_op_loader;
  localparam int unsigned WL    = 8;
  localparam int unsigned DEPTH = 4;
`ifdef GCD_OP_LOADER_SWAP_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_op_loader_if #(.WL(WL), .DEPTH(DEPTH)) bus ();

  gcd_op_loader #(.WL(WL), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected stored pair {a, b} given the received bytes.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
    if (SWAP && (b > a)) return {b, a};
    return {a, b};
  endfunction

  task automatic chk_head(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] e;
    e = model(a, b);
    chk({tag, "_val"}, bus.ops_val, 1);
    chk({tag, "_a"}, bus.op_a, e[15:8]);
    chk({tag, "_b"}, bus.op_b, e[7:0]);
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] a, input logic [7:0] b);
    chk_head(tag, a, b);
    bus.ops_rdy = 1'b1;
    @(posedge clk); #1;
    bus.ops_rdy = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the edge that took the byte.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.in_val  = 1'b1;
    bus.in_data = b;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (bus.in_rdy) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    bus.in_val = 1'b0;
    chk("send_timeout", 32'(done), 1);
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus.in_val  = 1'b0;
    bus.in_data = '0;
    bus.ops_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0]  bytes [18];
  logic [15:0] q [$];
  logic [15:0] e;
  int          sent, popped;

  initial begin
    // Reset state
    apply_reset();
    chk("rst_in_rdy", bus.in_rdy, 1);
    chk("rst_ops_val", bus.ops_val, 0);
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_b", bus.op_b, 0);
    chk("rst_count", bus.count, 0);

    // Basic pair
    send_byte(8'h30);
    chk("basic_after_a_val", bus.ops_val, 0);
    chk("basic_after_a_rdy", bus.in_rdy, 1);
    send_byte(8'h12);
    chk_head("basic", 8'h30, 8'h12);
    chk("basic_count", bus.count, 1);

    // Fill and stall
    apply_reset();
    send_byte(8'h50); send_byte(8'h10);
    send_byte(8'h60); send_byte(8'h20);
    send_byte(8'h70); send_byte(8'h30);
    send_byte(8'h80); send_byte(8'h40);
    chk("fill_count4", bus.count, 4);
    chk("fill_rdy_a", bus.in_rdy, 1);
    send_byte(8'h90);
    bus.in_val  = 1'b1;
    bus.in_data = 8'h11;
    @(negedge clk);
    chk("fill_b_stall", bus.in_rdy, 0);
    @(posedge clk); #1;
    chk("fill_still4", bus.count, 4);
    bus.ops_rdy = 1'b1;
    @(negedge clk);
    chk("fill_b_stall_pop", bus.in_rdy, 0);
    @(posedge clk); #1;
    bus.ops_rdy = 1'b0;
    chk("fill_count3", bus.count, 3);
    chk_head("fill_head2", 8'h60, 8'h20);
    chk("fill_rdy_free", bus.in_rdy, 1);
    @(posedge clk); #1;
    bus.in_val = 1'b0;
    chk("fill_count4b", bus.count, 4);
    pop_expect("fill_p2", 8'h60, 8'h20);
    pop_expect("fill_p3", 8'h70, 8'h30);
    pop_expect("fill_p4", 8'h80, 8'h40);
    pop_expect("fill_p5", 8'h90, 8'h11);
    chk("fill_empty", bus.ops_val, 0);
    chk("fill_count0", bus.count, 0);

    // Order and wrap with random ops_rdy
    apply_reset();
    for (int i = 1; i <= 9; i++) begin
      bytes[2*i-2] = 8'(i);
      bytes[2*i-1] = 8'(2*i);
    end
    sent   = 0;
    popped = 0;
    for (int cyc = 0; cyc < 400 && popped < 9; cyc++) begin
      bus.in_val  = (sent < 18);
      bus.in_data = (sent < 18) ? bytes[sent] : 8'h00;
      bus.ops_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (bus.ops_val && bus.ops_rdy) begin
        e = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        chk("wrap_head", {16'h0, bus.op_a, bus.op_b}, {16'h0, e});
        popped++;
      end
      if (bus.in_val && bus.in_rdy) begin
        if (sent % 2 == 1) q.push_back(model(bytes[sent-1], bytes[sent]));
        sent++;
      end
      @(posedge clk); #1;
      chk("wrap_count", bus.count, q.size());
    end
    bus.in_val  = 1'b0;
    bus.ops_rdy = 1'b0;
    chk("wrap_sent", sent, 18);
    chk("wrap_popped", popped, 9);
    chk("wrap_empty", bus.ops_val, 0);

    // Simultaneous push and pop
    apply_reset();
    send_byte(8'h21); send_byte(8'h01);
    send_byte(8'h22); send_byte(8'h02);
    chk("sim_count2", bus.count, 2);
    send_byte(8'h23);
    bus.in_val  = 1'b1;
    bus.in_data = 8'h03;
    bus.ops_rdy = 1'b1;
    @(negedge clk);
    chk("sim_rdy", bus.in_rdy, 1);
    @(posedge clk); #1;
    bus.in_val  = 1'b0;
    bus.ops_rdy = 1'b0;
    chk("sim_count_same", bus.count, 2);
    pop_expect("sim_head", 8'h22, 8'h02);
    pop_expect("sim_tail", 8'h23, 8'h03);

    // Reset mid-operation
    apply_reset();
    send_byte(8'h41); send_byte(8'h01);
    send_byte(8'h42); send_byte(8'h02);
    send_byte(8'h43); send_byte(8'h03);
    send_byte(8'h44);
    chk("mid_count3", bus.count, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_ops_val", bus.ops_val, 0);
    chk("mid_count0", bus.count, 0);
    chk("mid_in_rdy", bus.in_rdy, 1);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send_byte(8'h05);
    chk("mid_no_pair", bus.ops_val, 0);
    send_byte(8'h07);
    chk("mid_count1", bus.count, 1);
    chk_head("mid_head", 8'h05, 8'h07);

    // Swap feature and equal operands
    apply_reset();
    send_byte(8'h04); send_byte(8'h09);
    chk_head("swap_4_9", 8'h04, 8'h09);
    chk("swap_a_lit", bus.op_a, SWAP ? 32'h09 : 32'h04);
    pop_expect("swap_pop", 8'h04, 8'h09);
    send_byte(8'h06); send_byte(8'h06);
    chk_head("swap_eq", 8'h06, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
